microwave_ctrl: RTL

- Front-end controller for the microwave; sits directly upstream of the countdown timer.
- Collects keypad digits into a 3-digit entry buffer (M:S S) and streams them into the timer over its serial load interface.
- Gates the timer enable and the magnetron from the start/stop buttons and the door switch.
- Consumes the timer's zero flag and raises a finite-length done beep.

---
 rtl/microwave_pkg.sv | 33 +++
 rtl/btn_edge.sv | 38 +++
 rtl/microwave_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_pkg
//  Description : Shared types and constants for the microwave front-end
//                controller and the countdown timer it feeds. Holds the
//                controller state encoding, keypad digit width, entry
//                buffer depth and a BCD digit qualifier.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  localparam int DIGIT_W    = 4;  // one BCD digit
  localparam int NUM_DIGITS = 3;  // M : S S
  localparam int BCD_MAX    = 9;

  // The encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // True when a keypad code is a legal decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Registered falling-edge detector for an active-low,
//                already debounced push button. Produces one registered
//                pulse per 1->0 transition; a held button does not repeat.
//  Ports       : clk      - system clock, rising edge
//                clrn     - asynchronous active-low reset
//                btn_n_i  - button level, active-low
//                press_o  - one-cycle press pulse (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic clrn,
  input  logic btn_n_i,
  output logic press_o
);

  logic last_q;
  logic press_q;

  // last_q resets to 1 (released) so a button already held through reset
  // is reported once as soon as reset lifts.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      last_q  <= btn_n_i;
      press_q <= last_q & ~btn_n_i;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/microwave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_ctrl
//  Description : Microwave front-end controller. Collects keypad digits into
//                a 3-digit M:SS buffer, streams them serially into the
//                countdown timer, gates timer enable and magnetron from the
//                start/stop buttons and door switch, and sounds a finite
//                done beep when the timer reaches zero. All outputs are
//                registered.
//  Ports       : clk, clrn               - clock, async active-low reset
//                key_valid, key_data     - keypad strobe and BCD digit
//                startn, stopn           - active-low button levels
//                door_closed, timer_zero - door switch, timer at 0:00
//                timer_clrn/loadn/en/data- timer control and serial load
//                mag_on, done_beep       - magnetron and buzzer drive
//                state_o                 - current FSM state
//  Revision    : 1.0 - initial release
// ============================================================================
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int BEEP_CYCLES = 8,
  parameter int BEEP_W      = 4
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_data,
  input  logic               startn,
  input  logic               stopn,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic               timer_clrn,
  output logic               timer_loadn,
  output logic               timer_en,
  output logic [DIGIT_W-1:0] timer_data,
  output logic               mag_on,
  output logic               done_beep,
  output logic [2:0]         state_o
);

  logic start_press;
  logic stop_press;

  btn_edge u_start_edge (
    .clk     (clk),
    .clrn    (clrn),
    .btn_n_i (startn),
    .press_o (start_press)
  );

  btn_edge u_stop_edge (
    .clk     (clk),
    .clrn    (clrn),
    .btn_n_i (stopn),
    .press_o (stop_press)
  );

  state_t              state_q, state_d;
  logic [DIGIT_W-1:0]  mins_q, mins_d;
  logic [DIGIT_W-1:0]  tens_q, tens_d;
  logic [DIGIT_W-1:0]  ones_q, ones_d;
  logic [1:0]          load_cnt_q, load_cnt_d;
  logic                abort_q, abort_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;

  logic                timer_clrn_q, timer_clrn_d;
  logic                timer_loadn_q, timer_loadn_d;
  logic                timer_en_q, timer_en_d;
  logic [DIGIT_W-1:0]  timer_data_q, timer_data_d;
  logic                mag_on_q, mag_on_d;
  logic                done_beep_q, done_beep_d;

  logic key_ok;
  logic buf_nz;
  logic do_clear;
  logic do_shift;
  logic buf_zero;

  assign key_ok = key_valid & is_bcd(key_data);
  assign buf_nz = (mins_q | tens_q | ones_q) != '0;

  // --------------------------------------------------------------------------
  // Next state and next-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mins_d     = mins_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    load_cnt_d = load_cnt_q;
    abort_d    = abort_q;
    beep_cnt_d = beep_cnt_q;
    do_clear   = 1'b0;
    do_shift   = 1'b0;
    buf_zero   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (stop_press)  do_clear = 1'b1;
        else if (key_ok) do_shift = 1'b1;
      end

      ENTRY: begin
        if (stop_press) begin
          do_clear = 1'b1;
        end else if (start_press && door_closed && buf_nz) begin
          state_d    = LOAD;
          load_cnt_d = 2'd0;
          abort_d    = 1'b0;
        end else if (key_ok) begin
          do_shift = 1'b1;
        end
      end

      // The load always runs to completion so the timer never holds a
      // half-shifted value; a stop or door-open seen on the way only
      // changes where the sequence lands.
      LOAD: begin
        abort_d = abort_q | stop_press | ~door_closed;
        if (load_cnt_q == 2'(NUM_DIGITS - 1)) begin
          state_d = abort_d ? PAUSE : COOK;
        end else begin
          load_cnt_d = load_cnt_q + 2'd1;
        end
      end

      // timer_zero is tested first: reaching zero outranks a concurrent
      // stop or door-open.
      COOK: begin
        if (timer_zero) begin
          state_d    = DONE;
          beep_cnt_d = '0;
        end else if (stop_press || !door_closed) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (stop_press) begin
          do_clear = 1'b1;
        end else if (start_press && door_closed) begin
          state_d = COOK;
        end
      end

      DONE: begin
        if (stop_press || beep_cnt_q == BEEP_W'(BEEP_CYCLES - 1)) begin
          state_d  = IDLE;
          buf_zero = 1'b1;
        end else begin
          beep_cnt_d = beep_cnt_q + BEEP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (do_shift) begin
      mins_d  = tens_q;
      tens_d  = ones_q;
      ones_d  = key_data;
      state_d = ENTRY;
    end

    if (do_clear) begin
      state_d  = IDLE;
      buf_zero = 1'b1;
    end

    if (buf_zero) begin
      mins_d = '0;
      tens_d = '0;
      ones_d = '0;
    end

    // Outputs are decoded from the next state and registered with it, so
    // they line up with state_o and no input reaches an output unregistered.
    timer_clrn_d  = ~do_clear;
    timer_loadn_d = (state_d != LOAD);
    timer_en_d    = (state_d == COOK);
    mag_on_d      = (state_d == COOK);
    done_beep_d   = (state_d == DONE);
    timer_data_d  = '0;
    if (state_d == LOAD) begin
      unique case (load_cnt_d)
        2'd0:    timer_data_d = mins_q;
        2'd1:    timer_data_d = tens_q;
        default: timer_data_d = ones_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      mins_q        <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
      load_cnt_q    <= 2'd0;
      abort_q       <= 1'b0;
      beep_cnt_q    <= '0;
      timer_clrn_q  <= 1'b1;
      timer_loadn_q <= 1'b1;
      timer_en_q    <= 1'b0;
      timer_data_q  <= '0;
      mag_on_q      <= 1'b0;
      done_beep_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mins_q        <= mins_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      load_cnt_q    <= load_cnt_d;
      abort_q       <= abort_d;
      beep_cnt_q    <= beep_cnt_d;
      timer_clrn_q  <= timer_clrn_d;
      timer_loadn_q <= timer_loadn_d;
      timer_en_q    <= timer_en_d;
      timer_data_q  <= timer_data_d;
      mag_on_q      <= mag_on_d;
      done_beep_q   <= done_beep_d;
    end
  end

  assign timer_clrn  = timer_clrn_q;
  assign timer_loadn = timer_loadn_q;
  assign timer_en    = timer_en_q;
  assign timer_data  = timer_data_q;
  assign mag_on      = mag_on_q;
  assign done_beep   = done_beep_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire
